// File: rtl/hazard_pipe_reg.sv
// Inter-stage pipeline register with stall (hold) and flush (bubble) control.
// Optional statistics counters are built when HAZARD_PIPE_STATS_EN is defined.
module hazard_pipe_reg #(
  parameter int                CTRL_W      = 4,
  parameter int                DATA_W      = 32,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
`ifdef HAZARD_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic              load;

  assign load = !flush_i && !stall_i;

  // Flush beats stall; the control bundle is forced safe whenever the stage is empty,
  // so valid=0 always comes with ctrl=CTRL_BUBBLE. Data is simply held on a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
    end else if (load) begin
      valid_q <= valid_i;
      ctrl_q  <= valid_i ? ctrl_i : CTRL_BUBBLE;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

`ifdef HAZARD_PIPE_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic             stall_hit;
  logic             bubble_hit;

  assign stall_hit  = stall_i && !flush_i && valid_q;
  assign bubble_hit = flush_i || (load && !valid_i);

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_hit && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (bubble_hit && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt_o  = stall_cnt;
  assign bubble_cnt_o = bubble_cnt;
`else
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_hazard_pipe_reg.sv
// Directed self-checking bench for hazard_pipe_reg; stats test runs when
// HAZARD_PIPE_STATS_EN is defined.
module tb_hazard_pipe_reg;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        valid_i;
  logic [3:0]  ctrl_i;
  logic [31:0] data_i;
  logic        valid_o;
  logic [3:0]  ctrl_o;
  logic [31:0] data_o;
`ifdef HAZARD_PIPE_STATS_EN
  logic [1:0]  stall_cnt_o;
  logic [1:0]  bubble_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  hazard_pipe_reg #(.CTRL_W(4), .DATA_W(32), .CTRL_BUBBLE(4'b0000), .CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .ctrl_i(ctrl_i),
    .data_i(data_i),
    .valid_o(valid_o),
    .ctrl_o(ctrl_o),
    .data_o(data_o)
`ifdef HAZARD_PIPE_STATS_EN
    ,
    .stall_cnt_o(stall_cnt_o),
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Empty stage must always present the bubble control value.
  always @(negedge clk) begin
    if (valid_o === 1'b0) begin
      total++;
      if (ctrl_o !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL invariant: ctrl_o=%b required 0000 while valid_o=0", ctrl_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stall_i = 0; flush_i = 0; valid_i = 1; ctrl_i = 4'b1001; data_i = 32'h0BAD_F00D;
    tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0 || ctrl_o !== 4'b0000 || data_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset: got %b/%b/%h required 0/0000/00000000", valid_o, ctrl_o, data_o);
    end
    #1 reset = 1'b0;
    valid_i = 0;
    tick();
  endtask

  task automatic test_load();
    valid_i = 1; ctrl_i = 4'b1011; data_i = 32'hDEAD_BEEF;
    tick();
    total++;
    if (valid_o !== 1'b1 || ctrl_o !== 4'b1011 || data_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("[TB] FAIL load: got %b/%b/%h required 1/1011/deadbeef", valid_o, ctrl_o, data_o);
    end
  endtask

  task automatic test_stall();
    stall_i = 1; ctrl_i = 4'b0101; data_i = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid_o !== 1'b1 || ctrl_o !== 4'b1011 || data_o !== 32'hDEAD_BEEF) begin
        bad++;
        $display("[TB] FAIL stall_hold[%0d]: got %b/%b/%h required 1/1011/deadbeef", i, valid_o, ctrl_o, data_o);
      end
    end
    stall_i = 0;
    tick();
    total++;
    if (valid_o !== 1'b1 || ctrl_o !== 4'b0101 || data_o !== 32'h1234) begin
      bad++;
      $display("[TB] FAIL stall_release: got %b/%b/%h required 1/0101/00001234", valid_o, ctrl_o, data_o);
    end
  endtask

  task automatic test_flush_vs_stall();
    stall_i = 1; flush_i = 1; data_i = 32'h5555;
    tick();
    total++;
    if (valid_o !== 1'b0 || ctrl_o !== 4'b0000 || data_o !== 32'h1234) begin
      bad++;
      $display("[TB] FAIL flush_vs_stall: got %b/%b/%h required 0/0000/00001234", valid_o, ctrl_o, data_o);
    end
    stall_i = 0; flush_i = 0;
  endtask

  task automatic test_invalid_input();
    valid_i = 0; ctrl_i = 4'b1111; data_i = 32'hAAAA;
    tick();
    total++;
    if (valid_o !== 1'b0 || ctrl_o !== 4'b0000 || data_o !== 32'hAAAA) begin
      bad++;
      $display("[TB] FAIL invalid_input: got %b/%b/%h required 0/0000/0000aaaa", valid_o, ctrl_o, data_o);
    end
  endtask

  task automatic test_bubble_stall();
    stall_i = 1; valid_i = 1; ctrl_i = 4'b1011; data_i = 32'hBBBB;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (valid_o !== 1'b0 || ctrl_o !== 4'b0000 || data_o !== 32'hAAAA) begin
        bad++;
        $display("[TB] FAIL bubble_stall[%0d]: got %b/%b/%h required 0/0000/0000aaaa", i, valid_o, ctrl_o, data_o);
      end
    end
    stall_i = 0;
  endtask

  task automatic test_reset_mid_stall();
    valid_i = 1; ctrl_i = 4'b0110; data_i = 32'h77;
    tick();
    stall_i = 1;
    #2 reset = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0 || ctrl_o !== 4'b0000 || data_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid_stall: got %b/%b/%h required 0/0000/00000000", valid_o, ctrl_o, data_o);
    end
    #1 reset = 1'b0;
    tick();
    total++;
    if (valid_o !== 1'b0 || data_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL stall_after_reset: got %b/%h required 0/00000000", valid_o, data_o);
    end
    stall_i = 0;
    tick();
    total++;
    if (valid_o !== 1'b1 || ctrl_o !== 4'b0110 || data_o !== 32'h77) begin
      bad++;
      $display("[TB] FAIL load_after_reset: got %b/%b/%h required 1/0110/00000077", valid_o, ctrl_o, data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c [3] = '{4'b0001, 4'b1110, 4'b1000};
    logic [31:0] d [3] = '{32'h1111_0000, 32'h2222_0001, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      valid_i = 1; ctrl_i = c[i]; data_i = d[i];
      tick();
      total++;
      if (valid_o !== 1'b1 || ctrl_o !== c[i] || data_o !== d[i]) begin
        bad++;
        $display("[TB] FAIL back_to_back[%0d]: got %b/%b/%h required 1/%b/%h", i, valid_o, ctrl_o, data_o, c[i], d[i]);
      end
    end
  endtask

`ifdef HAZARD_PIPE_STATS_EN
  task automatic test_stats();
    stall_i = 0; flush_i = 0; valid_i = 1; ctrl_i = 4'b0001; data_i = 32'h1;
    reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    stall_i = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++;
      if (stall_cnt_o !== ((i > 3) ? 2'd3 : 2'(i)) || bubble_cnt_o !== 2'd0) begin
        bad++;
        $display("[TB] FAIL stats_stall[%0d]: got stall=%0d bubble=%0d required stall=%0d bubble=0",
                 i, stall_cnt_o, bubble_cnt_o, (i > 3) ? 3 : i);
      end
    end
    stall_i = 0; flush_i = 1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++;
      if (bubble_cnt_o !== 2'(i) || stall_cnt_o !== 2'd3) begin
        bad++;
        $display("[TB] FAIL stats_bubble[%0d]: got bubble=%0d stall=%0d required bubble=%0d stall=3",
                 i, bubble_cnt_o, stall_cnt_o, i);
      end
    end
    flush_i = 0;
  endtask
`endif

  initial begin
    reset = 1'b1; stall_i = 0; flush_i = 0; valid_i = 0; ctrl_i = '0; data_i = '0;
    #12 reset = 1'b0;
    test_reset();
    test_load();
    test_stall();
    test_flush_vs_stall();
    test_invalid_input();
    test_bubble_stall();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef HAZARD_PIPE_STATS_EN
    test_stats();
`endif
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
